// File: rtl/axi_rd_arbiter.sv
// Read-path interconnect: round-robin arbitration of MASTER_NUM AXI4 AR/R masters onto
// SLAVE_NUM slaves, one burst in flight, with an internal DECERR slave for unmapped reads.

// Address decoder for the fixed six-region slave map; one-hot select, all-zero if unmapped.
module decoder #(
  parameter int unsigned SLAVE_NUM = 6
) (
  input  logic [31:0]          addr,
  output logic [SLAVE_NUM-1:0] sel
);

  localparam int unsigned MAP_NUM = 6;

  logic [MAP_NUM-1:0] hit;

  always_comb begin
    hit    = '0;
    hit[0] = (addr <= 32'h0000_3FFF);
    hit[1] = (addr >= 32'h0001_0000) && (addr <= 32'h0001_FFFF);
    hit[2] = (addr >= 32'h0002_0000) && (addr <= 32'h0002_FFFF);
    hit[3] = (addr >= 32'h1000_0000) && (addr <= 32'h1000_03FF);
    hit[4] = (addr >= 32'h1001_0000) && (addr <= 32'h1001_03FF);
    hit[5] = (addr >= 32'h2000_0000) && (addr <= 32'h207F_FFFF);
  end

  assign sel = SLAVE_NUM'(hit);

endmodule

module axi_rd_arbiter #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned SLAVE_NUM  = 6
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [32*MASTER_NUM-1:0] m_araddr,
  input  logic [8*MASTER_NUM-1:0]  m_arlen,
  input  logic [MASTER_NUM-1:0]    m_arvalid,
  output logic [MASTER_NUM-1:0]    m_arready,
  output logic [31:0]              m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [MASTER_NUM-1:0]    m_rvalid,
  input  logic [MASTER_NUM-1:0]    m_rready,
  output logic [31:0]              s_araddr,
  output logic [7:0]               s_arlen,
  output logic [SLAVE_NUM-1:0]     s_arvalid,
  input  logic [SLAVE_NUM-1:0]     s_arready,
  input  logic [32*SLAVE_NUM-1:0]  s_rdata,
  input  logic [2*SLAVE_NUM-1:0]   s_rresp,
  input  logic [SLAVE_NUM-1:0]     s_rlast,
  input  logic [SLAVE_NUM-1:0]     s_rvalid,
  output logic [SLAVE_NUM-1:0]     s_rready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned RW = 2;
  localparam int unsigned GW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DERR = 2'd3;

  localparam logic [RW-1:0] RESP_DECERR = 2'b11;

  logic [1:0]           state, state_nxt;
  logic [GW-1:0]        ptr, ptr_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [SLAVE_NUM-1:0] sel, sel_nxt;
  logic [AW-1:0]        araddr_nxt;
  logic [LW-1:0]        arlen_nxt;
  logic [LW-1:0]        cnt, cnt_nxt;

  logic                 req_any;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        ptr_inc;
  logic [AW-1:0]        pick_addr;
  logic [LW-1:0]        pick_len;
  logic [SLAVE_NUM-1:0] dec_sel;
  logic [MASTER_NUM-1:0] gnt_oh;
  logic                 gm_rready;
  logic [DW-1:0]        sl_rdata;
  logic [RW-1:0]        sl_rresp;
  logic                 sl_rlast;
  logic                 sl_rvalid;
  logic                 derr_last;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin : rr_search
    int unsigned j;
    req_any = 1'b0;
    pick    = ptr;
    j       = 0;
    for (int unsigned k = 0; k < MASTER_NUM; k++) begin
      j = 32'(ptr) + k;
      if (j >= MASTER_NUM) j = j - MASTER_NUM;
      for (int unsigned i = 0; i < MASTER_NUM; i++) begin
        if (!req_any && (j == i) && m_arvalid[i]) begin
          req_any = 1'b1;
          pick    = GW'(i);
        end
      end
    end
  end

  always_comb begin : rr_advance
    int unsigned p;
    p = 32'(pick) + 1;
    if (p >= MASTER_NUM) p = 0;
    ptr_inc = GW'(p);
  end

  // Request payload of the candidate master.
  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (pick == GW'(i)) begin
        pick_addr = m_araddr[i*AW +: AW];
        pick_len  = m_arlen[i*LW +: LW];
      end
    end
  end

  decoder #(
    .SLAVE_NUM (SLAVE_NUM)
  ) u_dec (
    .addr (pick_addr),
    .sel  (dec_sel)
  );

  always_comb begin
    gnt_oh = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      gnt_oh[i] = (grant == GW'(i));
    end
  end

  assign gm_rready = |(m_rready & gnt_oh);

  // R-channel view of the selected slave (sel is one-hot, so OR-muxing is exact).
  always_comb begin
    sl_rdata  = '0;
    sl_rresp  = '0;
    sl_rlast  = 1'b0;
    sl_rvalid = 1'b0;
    for (int unsigned j = 0; j < SLAVE_NUM; j++) begin
      if (sel[j]) begin
        sl_rdata  = sl_rdata | s_rdata[j*DW +: DW];
        sl_rresp  = sl_rresp | s_rresp[j*RW +: RW];
        sl_rlast  = sl_rlast | s_rlast[j];
        sl_rvalid = sl_rvalid | s_rvalid[j];
      end
    end
  end

  assign derr_last = (cnt == s_arlen);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      sel      <= '0;
      s_araddr <= '0;
      s_arlen  <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      s_araddr <= araddr_nxt;
      s_arlen  <= arlen_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state and channel steering.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    sel_nxt    = sel;
    araddr_nxt = s_araddr;
    arlen_nxt  = s_arlen;
    cnt_nxt    = cnt;
    m_arready  = '0;
    m_rvalid   = '0;
    m_rdata    = '0;
    m_rresp    = '0;
    m_rlast    = 1'b0;
    s_arvalid  = '0;
    s_rready   = '0;

    case (state)
      IDLE: begin
        // A grant is suppressed while reset is applied so no AR handshake is faked.
        if (req_any && !ARESET) begin
          for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            m_arready[i] = (pick == GW'(i));
          end
          grant_nxt  = pick;
          araddr_nxt = pick_addr;
          arlen_nxt  = pick_len;
          sel_nxt    = dec_sel;
          ptr_nxt    = ptr_inc;
          cnt_nxt    = '0;
          state_nxt  = (|dec_sel) ? ADDR : DERR;
        end
      end

      ADDR: begin
        s_arvalid = sel;
        if (|(s_arready & sel)) state_nxt = DATA;
      end

      DATA: begin
        m_rvalid = gnt_oh & {MASTER_NUM{sl_rvalid}};
        s_rready = sel & {SLAVE_NUM{gm_rready}};
        m_rdata  = sl_rdata;
        m_rresp  = sl_rresp;
        m_rlast  = sl_rlast;
        if (sl_rvalid && gm_rready && sl_rlast) state_nxt = IDLE;
      end

      DERR: begin
        m_rvalid = gnt_oh;
        m_rresp  = RESP_DECERR;
        m_rlast  = derr_last;
        if (gm_rready) begin
          if (derr_last) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + LW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: address-map table plus hand-written burst sequences.
module tb_axi_rd_arbiter;

  localparam int unsigned MN = 2;
  localparam int unsigned SN = 6;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [32*MN-1:0]  m_araddr;
  logic [8*MN-1:0]   m_arlen;
  logic [MN-1:0]     m_arvalid;
  logic [MN-1:0]     m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [MN-1:0]     m_rvalid;
  logic [MN-1:0]     m_rready;
  logic [31:0]       s_araddr;
  logic [7:0]        s_arlen;
  logic [SN-1:0]     s_arvalid;
  logic [SN-1:0]     s_arready;
  logic [32*SN-1:0]  s_rdata;
  logic [2*SN-1:0]   s_rresp;
  logic [SN-1:0]     s_rlast;
  logic [SN-1:0]     s_rvalid;
  logic [SN-1:0]     s_rready;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]   addr;
    logic [SN-1:0] exp_sel;
    logic          exp_derr;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[8];

  axi_rd_arbiter #(.MASTER_NUM(MN), .SLAVE_NUM(SN)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    step();
    step();
    ARESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_3FFF, 6'b000001, 1'b0, 32'hD000_0000};
    vecs[1] = '{32'h0000_4000, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h207F_FFFF, 6'b100000, 1'b0, 32'hD000_0005};
    vecs[3] = '{32'h2080_0000, 6'b000000, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0002_0000, 6'b000100, 1'b0, 32'hD000_0002};
    vecs[5] = '{32'h1001_03FF, 6'b010000, 1'b0, 32'hD000_0004};
    vecs[6] = '{32'h1000_03FF, 6'b001000, 1'b0, 32'hD000_0003};
    vecs[7] = '{32'h1000_0400, 6'b000000, 1'b1, 32'h0000_0000};

    ARESET    = 1'b1;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arvalid = '0;
    m_rready  = '0;
    s_arready = '0;
    s_rresp   = '0;
    s_rlast   = '0;
    s_rvalid  = '0;
    for (int j = 0; j < int'(SN); j++) s_rdata[j*32 +: 32] = 32'hD000_0000 + 32'(j);

    // Reset state
    do_reset();
    look();
    chk("rst_m_arready", 64'(m_arready), 64'h0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'h0);
    chk("rst_m_rvalid",  64'(m_rvalid),  64'h0);
    chk("rst_s_rready",  64'(s_rready),  64'h0);
    chk("rst_s_araddr",  64'(s_araddr),  64'h0);
    chk("rst_s_arlen",   64'(s_arlen),   64'h0);

    // Master0 4-beat burst to s1
    m_araddr[31:0] = 32'h0001_0010;
    m_arlen[7:0]   = 8'd3;
    m_arvalid      = 2'b01;
    look();
    chk("t1_m_arready", 64'(m_arready), 64'h1);
    step();
    m_arvalid = '0;
    look();
    chk("t1_s_arvalid",   64'(s_arvalid), 64'b000010);
    chk("t1_s_araddr",    64'(s_araddr),  64'h0001_0010);
    chk("t1_s_arlen",     64'(s_arlen),   64'd3);
    chk("t1_no_arready",  64'(m_arready), 64'h0);
    s_arready = 6'b000010;
    step();
    s_arready    = '0;
    s_rresp[3:2] = 2'b01;
    m_rready     = 2'b01;
    for (int b = 0; b < 4; b++) begin
      s_rvalid       = 6'b000010;
      s_rlast        = (b == 3) ? 6'b000010 : 6'b000000;
      s_rdata[63:32] = 32'hA000_0000 + 32'(b);
      look();
      chk($sformatf("t1_b%0d_m_rvalid", b), 64'(m_rvalid), 64'b01);
      chk($sformatf("t1_b%0d_m_rdata", b),  64'(m_rdata),  64'(32'hA000_0000 + 32'(b)));
      chk($sformatf("t1_b%0d_m_rlast", b),  64'(m_rlast),  (b == 3) ? 64'h1 : 64'h0);
      chk($sformatf("t1_b%0d_m_rresp", b),  64'(m_rresp),  64'h1);
      chk($sformatf("t1_b%0d_s_rready", b), 64'(s_rready), 64'b000010);
      step();
    end
    s_rvalid = '0;
    s_rlast  = '0;
    s_rresp  = '0;
    m_rready = '0;
    look();
    chk("t1_idle_m_rvalid", 64'(m_rvalid), 64'h0);
    chk("t1_idle_s_rready", 64'(s_rready), 64'h0);

    // Both masters contend for s5: grants alternate from a fresh pointer
    do_reset();
    m_araddr  = {32'h2000_0000, 32'h2000_0000};
    m_arlen   = '0;
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] exp_g;
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      look();
      chk($sformatf("t2_r%0d_grant", r), 64'(m_arready), 64'(exp_g));
      step();
      look();
      chk($sformatf("t2_r%0d_addr_arready", r), 64'(m_arready), 64'h0);
      chk($sformatf("t2_r%0d_s_arvalid", r),    64'(s_arvalid), 64'b100000);
      s_arready = 6'b100000;
      step();
      s_arready = '0;
      s_rvalid  = 6'b100000;
      s_rlast   = 6'b100000;
      look();
      chk($sformatf("t2_r%0d_m_rvalid", r),      64'(m_rvalid),  64'(exp_g));
      chk($sformatf("t2_r%0d_data_arready", r),  64'(m_arready), 64'h0);
      chk($sformatf("t2_r%0d_m_rdata", r),       64'(m_rdata),   64'hD000_0005);
      step();
      s_rvalid = '0;
      s_rlast  = '0;
    end
    m_arvalid = '0;
    m_rready  = '0;

    // Master1 unmapped read: DECERR beats with a 5-cycle ready stall
    m_araddr[63:32] = 32'h0000_8000;
    m_arlen[15:8]   = 8'd2;
    m_arvalid       = 2'b10;
    look();
    chk("t3_m_arready", 64'(m_arready), 64'b10);
    step();
    m_arvalid = '0;
    for (int s = 0; s < 5; s++) begin
      look();
      chk($sformatf("t3_stall%0d_m_rvalid", s),  64'(m_rvalid),  64'b10);
      chk($sformatf("t3_stall%0d_m_rlast", s),   64'(m_rlast),   64'h0);
      chk($sformatf("t3_stall%0d_s_arvalid", s), 64'(s_arvalid), 64'h0);
      step();
    end
    m_rready = 2'b10;
    for (int b = 0; b < 3; b++) begin
      look();
      chk($sformatf("t3_b%0d_m_rvalid", b), 64'(m_rvalid), 64'b10);
      chk($sformatf("t3_b%0d_m_rresp", b),  64'(m_rresp),  64'h3);
      chk($sformatf("t3_b%0d_m_rdata", b),  64'(m_rdata),  64'h0);
      chk($sformatf("t3_b%0d_m_rlast", b),  64'(m_rlast),  (b == 2) ? 64'h1 : 64'h0);
      step();
    end
    m_rready = '0;
    look();
    chk("t3_idle_m_rvalid", 64'(m_rvalid), 64'h0);

    // AR backpressure from s3
    m_araddr[31:0] = 32'h1000_0004;
    m_arlen[7:0]   = 8'd0;
    m_arvalid      = 2'b01;
    look();
    chk("t4_m_arready", 64'(m_arready), 64'b01);
    step();
    m_arvalid = '0;
    for (int s = 0; s < 4; s++) begin
      look();
      chk($sformatf("t4_stall%0d_s_arvalid", s), 64'(s_arvalid), 64'b001000);
      chk($sformatf("t4_stall%0d_s_araddr", s),  64'(s_araddr),  64'h1000_0004);
      step();
    end
    s_arready = 6'b001000;
    look();
    chk("t4_accept_s_arvalid", 64'(s_arvalid), 64'b001000);
    step();
    s_arready = '0;
    s_rvalid  = 6'b001000;
    s_rlast   = 6'b001000;
    m_rready  = 2'b01;
    look();
    chk("t4_m_rvalid", 64'(m_rvalid), 64'b01);
    chk("t4_s_rready", 64'(s_rready), 64'b001000);
    chk("t4_m_rdata",  64'(m_rdata),  64'hD000_0003);
    step();
    s_rvalid = '0;
    s_rlast  = '0;
    m_rready = '0;

    // Address-map boundaries
    foreach (vecs[v]) begin
      m_araddr[31:0] = vecs[v].addr;
      m_arlen[7:0]   = 8'd0;
      m_arvalid      = 2'b01;
      look();
      chk($sformatf("map%0d_m_arready", v), 64'(m_arready), 64'b01);
      step();
      m_arvalid = '0;
      look();
      chk($sformatf("map%0d_s_arvalid", v), 64'(s_arvalid), 64'(vecs[v].exp_sel));
      if (!vecs[v].exp_derr) begin
        s_arready = vecs[v].exp_sel;
        step();
        s_arready = '0;
        s_rvalid  = vecs[v].exp_sel;
        s_rlast   = vecs[v].exp_sel;
        m_rready  = 2'b01;
        look();
        chk($sformatf("map%0d_m_rvalid", v), 64'(m_rvalid), 64'b01);
        chk($sformatf("map%0d_m_rdata", v),  64'(m_rdata),  64'(vecs[v].exp_data));
        chk($sformatf("map%0d_m_rresp", v),  64'(m_rresp),  64'h0);
        chk($sformatf("map%0d_m_rlast", v),  64'(m_rlast),  64'h1);
        step();
      end else begin
        m_rready = 2'b01;
        look();
        chk($sformatf("map%0d_m_rvalid", v), 64'(m_rvalid), 64'b01);
        chk($sformatf("map%0d_m_rresp", v),  64'(m_rresp),  64'h3);
        chk($sformatf("map%0d_m_rdata", v),  64'(m_rdata),  64'h0);
        chk($sformatf("map%0d_m_rlast", v),  64'(m_rlast),  64'h1);
        step();
      end
      s_rvalid = '0;
      s_rlast  = '0;
      m_rready = '0;
      look();
      chk($sformatf("map%0d_idle_m_rvalid", v), 64'(m_rvalid), 64'h0);
    end

    // Reset in the middle of a 4-beat burst
    m_araddr[31:0] = 32'h0001_0000;
    m_arlen[7:0]   = 8'd3;
    m_arvalid      = 2'b01;
    look();
    chk("t6_m_arready", 64'(m_arready), 64'b01);
    step();
    m_arvalid = '0;
    s_arready = 6'b000010;
    look();
    chk("t6_s_arvalid", 64'(s_arvalid), 64'b000010);
    step();
    s_arready = '0;
    s_rvalid  = 6'b000010;
    s_rlast   = '0;
    m_rready  = 2'b01;
    for (int b = 0; b < 2; b++) begin
      look();
      chk($sformatf("t6_b%0d_m_rvalid", b), 64'(m_rvalid), 64'b01);
      step();
    end
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    look();
    chk("t6_post_rst_m_rvalid",  64'(m_rvalid),  64'h0);
    chk("t6_post_rst_s_rready",  64'(s_rready),  64'h0);
    chk("t6_post_rst_s_arvalid", 64'(s_arvalid), 64'h0);
    chk("t6_post_rst_m_arready", 64'(m_arready), 64'h0);
    s_rvalid = '0;
    m_rready = '0;
    step();
    m_araddr  = {32'h0001_0020, 32'h0000_4000};
    m_arlen   = '0;
    m_arvalid = 2'b11;
    look();
    chk("t6_ptr_reset_grant", 64'(m_arready), 64'b01);
    step();
    m_arvalid = 2'b10;
    m_rready  = 2'b01;
    look();
    chk("t6_derr_m_rvalid", 64'(m_rvalid), 64'b01);
    chk("t6_derr_m_rresp",  64'(m_rresp),  64'h3);
    step();
    m_rready = '0;
    look();
    chk("t6_m1_grant", 64'(m_arready), 64'b10);
    step();
    m_arvalid = '0;
    look();
    chk("t6_m1_s_arvalid", 64'(s_arvalid), 64'b000010);
    chk("t6_m1_s_araddr",  64'(s_araddr),  64'h0001_0020);
    s_arready = 6'b000010;
    step();
    s_arready = '0;
    s_rvalid  = 6'b000010;
    s_rlast   = 6'b000010;
    m_rready  = 2'b10;
    look();
    chk("t6_m1_m_rvalid", 64'(m_rvalid), 64'b10);
    chk("t6_m1_m_rlast",  64'(m_rlast),  64'h1);
    step();
    s_rvalid = '0;
    s_rlast  = '0;
    m_rready = '0;
    look();
    chk("t6_final_m_rvalid", 64'(m_rvalid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
